// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer and the score counter.
// State encodings are visible on the state output for display blinking.
package timer_pkg;

  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_FREQ-1 while enabled and pulses tick on the
// terminal count. clr wins over en so a restart always begins a fresh second.
module sec_tick_gen #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic sclk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc_q;

  assign tick = en && (presc_q == TERM);

  always_ff @(posedge sclk) begin
    if (rst || clr) begin
      presc_q <= '0;
    end else if (en) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Seconds countdown timer: loads START_VAL on key_start, decrements once per second
// in RUN, stops at zero with a one-cycle done pulse.
module down_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned START_VAL = 60
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_pause,
  output logic [CNT_W-1:0] cnt,
  output logic             running,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] START = CNT_W'(START_VAL);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, done_q, done_d;
  logic             tick, presc_en, presc_clr;

  // A pause pulse freezes the prescaler in the same cycle, so a coincident tick is
  // dropped and the fractional second survives until resume.
  assign presc_en  = (state_q == ST_RUN) && !key_pause;
  assign presc_clr = key_start;

  sec_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_sec_tick_gen (
    .sclk (sclk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    if (key_start) begin
      state_d = ST_RUN;
      cnt_d   = START;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (key_pause) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (cnt_q > ONE) begin
              cnt_d = cnt_q - ONE;
            end else begin
              cnt_d   = '0;
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (key_pause) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= START;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= done_d;
    end
  end

  assign cnt     = cnt_q;
  assign running = running_q;
  assign done    = done_q;
  assign state   = state_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer with CLK_FREQ=4, START_VAL=3.
// Outputs are sampled 1 time unit after each rising edge.
module tb_down_timer;

  logic       sclk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b0;
  logic       key_pause = 1'b0;
  logic [6:0] cnt;
  logic       running;
  logic       done;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int d0;

  down_timer #(
    .CLK_FREQ(4),
    .START_VAL(3)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .key_start (key_start),
    .key_pause (key_pause),
    .cnt       (cnt),
    .running   (running),
    .done      (done),
    .state     (state)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) if (done === 1'b1) done_seen++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_cnt", 8'(cnt), 8'd3);
    chk("rst_running", 8'(running), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    rst = 1'b0;

    // 1: full countdown, start pulse at cycle 0
    d0 = done_seen;
    key_start = 1'b1; step(1); key_start = 1'b0;
    chk("s1_c1_running", 8'(running), 8'd1);
    chk("s1_c1_state", 8'(state), 8'd1);
    chk("s1_c1_cnt", 8'(cnt), 8'd3);
    step(3); chk("s1_c4_cnt", 8'(cnt), 8'd3);
    step(1); chk("s1_c5_cnt", 8'(cnt), 8'd2);
    step(3); chk("s1_c8_cnt", 8'(cnt), 8'd2);
    step(1); chk("s1_c9_cnt", 8'(cnt), 8'd1);
    step(3); chk("s1_c12_cnt", 8'(cnt), 8'd1);
    chk("s1_c12_done", 8'(done), 8'd0);
    step(1);
    chk("s1_c13_cnt", 8'(cnt), 8'd0);
    chk("s1_c13_done", 8'(done), 8'd1);
    chk("s1_c13_state", 8'(state), 8'd3);
    chk("s1_c13_running", 8'(running), 8'd0);
    step(1);
    chk("s1_c14_done", 8'(done), 8'd0);
    chk("s1_c14_state", 8'(state), 8'd3);
    chk("s1_done_count", 8'(done_seen - d0), 8'd1);

    // 2: pause with prescaler at 2, resume, decrement 2 cycles after running rises
    key_start = 1'b1; step(1); key_start = 1'b0;
    step(2);
    key_pause = 1'b1; step(1); key_pause = 1'b0;
    chk("s2_pause_state", 8'(state), 8'd2);
    chk("s2_pause_running", 8'(running), 8'd0);
    step(10);
    chk("s2_hold_state", 8'(state), 8'd2);
    chk("s2_hold_cnt", 8'(cnt), 8'd3);
    chk("s2_hold_running", 8'(running), 8'd0);
    key_pause = 1'b1; step(1); key_pause = 1'b0;
    chk("s2_resume_running", 8'(running), 8'd1);
    chk("s2_resume_cnt", 8'(cnt), 8'd3);
    step(1); chk("s2_r2_cnt", 8'(cnt), 8'd3);
    step(1); chk("s2_r3_cnt", 8'(cnt), 8'd2);

    // 3: restart on the tick cycle with cnt=1
    step(4); chk("s3_cnt1", 8'(cnt), 8'd1);
    step(3); chk("s3_tickcyc_cnt", 8'(cnt), 8'd1);
    d0 = done_seen;
    key_start = 1'b1; step(1); key_start = 1'b0;
    chk("s3_restart_cnt", 8'(cnt), 8'd3);
    chk("s3_restart_state", 8'(state), 8'd1);
    chk("s3_restart_done", 8'(done), 8'd0);
    step(11);
    chk("s3_c12_cnt", 8'(cnt), 8'd1);
    chk("s3_no_done", 8'(done_seen - d0), 8'd0);
    step(1);
    chk("s3_c13_done", 8'(done), 8'd1);
    chk("s3_c13_state", 8'(state), 8'd3);

    // 4: pause ignored in DONE/IDLE; start beats pause from IDLE and RUN
    key_pause = 1'b1; step(1); key_pause = 1'b0;
    chk("s4_done_pause_state", 8'(state), 8'd3);
    chk("s4_done_pause_cnt", 8'(cnt), 8'd0);
    rst = 1'b1; step(1); rst = 1'b0;
    key_pause = 1'b1; step(1); key_pause = 1'b0;
    chk("s4_idle_pause_state", 8'(state), 8'd0);
    chk("s4_idle_pause_cnt", 8'(cnt), 8'd3);
    key_start = 1'b1; key_pause = 1'b1; step(1); key_start = 1'b0; key_pause = 1'b0;
    chk("s4_idle_both_state", 8'(state), 8'd1);
    chk("s4_idle_both_cnt", 8'(cnt), 8'd3);
    step(2);
    key_start = 1'b1; key_pause = 1'b1; step(1); key_start = 1'b0; key_pause = 1'b0;
    chk("s4_run_both_state", 8'(state), 8'd1);
    chk("s4_run_both_running", 8'(running), 8'd1);
    chk("s4_run_both_cnt", 8'(cnt), 8'd3);
    step(3); chk("s4_c4_cnt", 8'(cnt), 8'd3);
    step(1); chk("s4_c5_cnt", 8'(cnt), 8'd2);

    // 5: reset mid-RUN with cnt=2
    d0 = done_seen;
    rst = 1'b1; step(1); rst = 1'b0;
    chk("s5_state", 8'(state), 8'd0);
    chk("s5_cnt", 8'(cnt), 8'd3);
    chk("s5_running", 8'(running), 8'd0);
    chk("s5_done", 8'(done), 8'd0);
    step(12);
    chk("s5_later_cnt", 8'(cnt), 8'd3);
    chk("s5_later_state", 8'(state), 8'd0);
    chk("s5_no_done", 8'(done_seen - d0), 8'd0);

    // 6: pause on the final tick cycle; held prescaler ticks on the first RUN cycle
    key_start = 1'b1; step(1); key_start = 1'b0;
    step(11);
    chk("s6_c12_cnt", 8'(cnt), 8'd1);
    d0 = done_seen;
    key_pause = 1'b1; step(1); key_pause = 1'b0;
    chk("s6_pause_state", 8'(state), 8'd2);
    chk("s6_pause_cnt", 8'(cnt), 8'd1);
    chk("s6_pause_done", 8'(done), 8'd0);
    step(1);
    key_pause = 1'b1; step(1); key_pause = 1'b0;
    chk("s6_resume_state", 8'(state), 8'd1);
    chk("s6_resume_cnt", 8'(cnt), 8'd1);
    step(1);
    chk("s6_done", 8'(done), 8'd1);
    chk("s6_done_cnt", 8'(cnt), 8'd0);
    chk("s6_done_state", 8'(state), 8'd3);
    step(1);
    chk("s6_done_count", 8'(done_seen - d0), 8'd1);
    chk("s6_done_low", 8'(done), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
